// File: rtl/wb_pkg.sv
// Shared defaults and the queue-entry bit layout for the write-back queue.
// Entry layout, LSB first: valid bit, destination address, result data.
package wb_pkg;

   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_ADDR_WIDTH = 5;
   localparam int WB_RD_DEPTH   = 2;
   localparam int WB_Q_DEPTH    = 4;

   localparam int ENT_VLD_BIT  = 0;
   localparam int ENT_ADDR_LSB = 1;

   function automatic int wb_log2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int wb_ent_data_lsb(input int aw);
      return ENT_ADDR_LSB + aw;
   endfunction

   function automatic int wb_ent_width(input int aw, input int dw);
      return ENT_ADDR_LSB + aw + dw;
   endfunction

endpackage

// File: rtl/wb_fwd_lookup.sv
// One read-port forwarding search over the queue; combinational, youngest match wins.
// Entries are scanned oldest (head) to youngest so later matches override earlier ones.
module wb_fwd_lookup
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = WB_DATA_WIDTH,
   parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
   parameter int Q_DEPTH    = WB_Q_DEPTH,
   parameter int PW         = wb_log2(Q_DEPTH)
) (
   input  logic [Q_DEPTH-1:0]            vld,
   input  logic [Q_DEPTH*ADDR_WIDTH-1:0] addr,
   input  logic [Q_DEPTH*DATA_WIDTH-1:0] data,
   input  logic [PW-1:0]                 head,
   input  logic [ADDR_WIDTH-1:0]         rr,
   output logic                          hit,
   output logic [DATA_WIDTH-1:0]         dat
);

   logic [PW-1:0] idx;

   always_comb begin
      hit = 1'b0;
      dat = '0;
      idx = '0;
      if (rr != '0) begin
         for (int k = 0; k < Q_DEPTH; k++) begin
            idx = head + PW'(k);
            if (vld[idx] && (addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH] == rr)) begin
               hit = 1'b1;
               dat = data[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

endmodule

// File: rtl/writeback_queue.sv
// In-order write-back FIFO feeding register_file, with forwarding of queued results to read ports.
// Result reaches wr/rw/d one cycle after acceptance; in_ready drops only when count hits Q_DEPTH.
module writeback_queue
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = WB_DATA_WIDTH,
   parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
   parameter int RD_DEPTH   = WB_RD_DEPTH,
   parameter int Q_DEPTH    = WB_Q_DEPTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [ADDR_WIDTH-1:0]          in_addr,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic                           wr_hold,
   output logic                           wr,
   output logic [ADDR_WIDTH-1:0]          rw,
   output logic [DATA_WIDTH-1:0]          d,
   input  logic [ADDR_WIDTH*RD_DEPTH-1:0] rr,
   input  logic [DATA_WIDTH*RD_DEPTH-1:0] rf_q,
   output logic [DATA_WIDTH*RD_DEPTH-1:0] op_q,
   output logic [RD_DEPTH-1:0]            fwd_hit,
   output logic [wb_log2(Q_DEPTH):0]      count,
   output logic                           empty
);

   localparam int PW = wb_log2(Q_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = wb_ent_width(ADDR_WIDTH, DATA_WIDTH);
   localparam int DL = wb_ent_data_lsb(ADDR_WIDTH);

   logic [EW-1:0] ent_q [Q_DEPTH];
   logic [EW-1:0] ent_d [Q_DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          push;

   logic [Q_DEPTH-1:0]            vld_flat;
   logic [Q_DEPTH*ADDR_WIDTH-1:0] addr_flat;
   logic [Q_DEPTH*DATA_WIDTH-1:0] data_flat;

   // Ready and drain derive from registered count only; in_valid/wr_hold never reach in_ready.
   always_comb begin
      in_ready = (count_q != CW'(Q_DEPTH));
      empty    = (count_q == '0);
      count    = count_q;
      wr       = (count_q != '0) && !wr_hold;
      rw       = ent_q[head_q][DL-1:ENT_ADDR_LSB];
      d        = ent_q[head_q][DL +: DATA_WIDTH];
      push     = in_valid && in_ready && (in_addr != '0);
   end

   always_comb begin
      ent_d  = ent_q;
      head_d = head_q;
      tail_d = tail_q;
      if (push) begin
         ent_d[tail_q] = {in_data, in_addr, 1'b1};
         tail_d        = tail_q + 1'b1;
      end
      if (wr) begin
         ent_d[head_q][ENT_VLD_BIT] = 1'b0;
         head_d                     = head_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(wr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < Q_DEPTH; i++) ent_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         ent_q   <= ent_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      for (int q = 0; q < Q_DEPTH; q++) begin
         vld_flat[q]                            = ent_q[q][ENT_VLD_BIT];
         addr_flat[q*ADDR_WIDTH +: ADDR_WIDTH]  = ent_q[q][DL-1:ENT_ADDR_LSB];
         data_flat[q*DATA_WIDTH +: DATA_WIDTH]  = ent_q[q][DL +: DATA_WIDTH];
      end
   end

   for (genvar i = 0; i < RD_DEPTH; i++) begin : g_port
      logic                  hit;
      logic [DATA_WIDTH-1:0] fdat;

      wb_fwd_lookup #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .Q_DEPTH    (Q_DEPTH),
         .PW         (PW)
      ) u_lookup (
         .vld  (vld_flat),
         .addr (addr_flat),
         .data (data_flat),
         .head (head_q),
         .rr   (rr[i*ADDR_WIDTH +: ADDR_WIDTH]),
         .hit  (hit),
         .dat  (fdat)
      );

      assign fwd_hit[i]                       = hit;
      assign op_q[i*DATA_WIDTH +: DATA_WIDTH] = hit ? fdat : rf_q[i*DATA_WIDTH +: DATA_WIDTH];
   end

endmodule

// File: tb/tb_writeback_queue.sv
// Randomized and directed bench for writeback_queue; a list of pending writes models the queue.
module tb_writeback_queue;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int RD = 2;
   localparam int QD = 4;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [AW-1:0]    in_addr;
   logic [DW-1:0]    in_data;
   logic             wr_hold;
   logic             wr;
   logic [AW-1:0]    rw;
   logic [DW-1:0]    d;
   logic [AW*RD-1:0] rr;
   logic [DW*RD-1:0] rf_q;
   logic [DW*RD-1:0] op_q;
   logic [RD-1:0]    fwd_hit;
   logic [2:0]       count;
   logic             empty;

   writeback_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_DEPTH(RD), .Q_DEPTH(QD)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .wr_hold(wr_hold),
      .wr(wr), .rw(rw), .d(d), .rr(rr), .rf_q(rf_q), .op_q(op_q),
      .fwd_hit(fwd_hit), .count(count), .empty(empty)
   );

   always #5 clk = ~clk;

   int   vectors = 0;
   int   miscompares = 0;
   int   n_wr = 0;
   ent_t pend[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pending list is the expected register_file write sequence; youngest match forwards.
   int            m_sz;
   logic          m_wr;
   logic          m_hit;
   logic [DW-1:0] m_dat;
   logic [AW-1:0] m_rr;
   always @(negedge clk) begin
      if (!rst) begin
         m_sz = pend.size();
         chk("count", 64'(count), 64'(m_sz));
         chk("empty", 64'(empty), 64'(m_sz == 0));
         chk("in_ready", 64'(in_ready), 64'(m_sz != QD));
         m_wr = (m_sz != 0) && !wr_hold;
         chk("wr", 64'(wr), 64'(m_wr));
         for (int i = 0; i < RD; i++) begin
            m_rr  = rr[i*AW +: AW];
            m_hit = 1'b0;
            m_dat = rf_q[i*DW +: DW];
            if (m_rr != 0) begin
               foreach (pend[j]) begin
                  if (pend[j].a == m_rr) begin
                     m_hit = 1'b1;
                     m_dat = pend[j].d;
                  end
               end
            end
            chk("fwd_hit", 64'(fwd_hit[i]), 64'(m_hit));
            chk("op_q", 64'(op_q[i*DW +: DW]), 64'(m_dat));
         end
         if (wr) n_wr++;
         if (m_wr) begin
            chk("rw", 64'(rw), 64'(pend[0].a));
            chk("d", 64'(d), 64'(pend[0].d));
            void'(pend.pop_front());
         end
         if (in_valid && (m_sz != QD) && (in_addr != 0))
            pend.push_back('{a: in_addr, d: in_data});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] dd, input logic h);
      in_valid = v;
      in_addr  = a;
      in_data  = dd;
      wr_hold  = h;
   endtask

   int            w0;
   int            accepted;
   logic [AW*RD-1:0] rr_t;
   logic [DW*RD-1:0] rf_t;

   initial begin
      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      rr   = {5'd5, 5'd6};
      rf_q = {32'hCAFE0001, 32'hCAFE0002};
      #12;
      chk("rst_wr", 64'(wr), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
      chk("rst_op_q", 64'(op_q), 64'(rf_q));
      rst = 1'b0;
      step();

      // Three back-to-back results with an immediate drain.
      w0 = n_wr;
      drive(1'b1, 5'd5, 32'h11, 1'b0); step();
      drive(1'b1, 5'd6, 32'h22, 1'b0); step();
      drive(1'b1, 5'd5, 32'h33, 1'b0); step();
      drive(1'b0, '0, '0, 1'b0);
      repeat (4) step();
      chk("t1_wr_pulses", 64'(n_wr - w0), 64'd3);
      chk("t1_count", 64'(count), 64'd0);

      // Fill under hold, a fifth result is refused, then release.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, AW'(i), 32'h100 + DW'(i), 1'b1);
         step();
      end
      drive(1'b1, 5'd9, 32'h999, 1'b1);
      repeat (2) step();
      chk("t2_full_count", 64'(count), 64'd4);
      chk("t2_full_ready", 64'(in_ready), 64'd0);
      drive(1'b0, '0, '0, 1'b0);
      step();
      chk("t2_ready_back", 64'(in_ready), 64'd1);
      chk("t2_count3", 64'(count), 64'd3);
      repeat (4) step();
      chk("t2_drained", 64'(count), 64'd0);

      // Youngest duplicate forwards; the other port falls through to rf_q.
      drive(1'b1, 5'd7, 32'hAA, 1'b1); step();
      drive(1'b1, 5'd7, 32'hBB, 1'b1); step();
      drive(1'b0, '0, '0, 1'b1);
      rr   = {5'd7, 5'd3};
      rf_q = {32'h0, 32'h55};
      #1;
      chk("t3_op_q", 64'(op_q), {32'hBB, 32'h55});
      chk("t3_fwd_hit", 64'(fwd_hit), 64'b10);
      wr_hold = 1'b0;
      repeat (3) step();

      // Register 0 results are consumed without an entry.
      w0 = n_wr;
      drive(1'b1, 5'd0, 32'hFFFF, 1'b0); step();
      drive(1'b0, '0, '0, 1'b0);
      rr   = {5'd0, 5'd0};
      rf_q = {32'h1234, 32'h5678};
      #1;
      chk("t4_count", 64'(count), 64'd0);
      chk("t4_fwd_hit", 64'(fwd_hit), 64'd0);
      chk("t4_op_q", 64'(op_q), 64'(rf_q));
      repeat (3) step();
      chk("t4_no_wr", 64'(n_wr - w0), 64'd0);

      // Full queue released with continuous valid: streaming through pointer wrap.
      rr = {5'd1, 5'd2};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, AW'(i + 1), 32'h200 + DW'(i), 1'b1);
         step();
      end
      accepted = 0;
      wr_hold = 1'b0;
      in_addr = AW'(1 + ($urandom % 31));
      in_data = $urandom;
      for (int c = 0; c < 40 && accepted < 12; c++) begin
         logic took;
         took = in_ready;
         step();
         if (took) begin
            accepted++;
            in_addr = AW'(1 + ($urandom % 31));
            in_data = $urandom;
         end
         if (c >= 1) chk("t5_steady_count", 64'(count), 64'd3);
      end
      chk("t5_accepted", 64'(accepted), 64'd12);
      drive(1'b0, '0, '0, 1'b0);
      repeat (6) step();

      // Asynchronous reset between edges with three entries queued.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'd12, 32'h300 + DW'(i), 1'b1);
         step();
      end
      drive(1'b0, '0, '0, 1'b0);
      rr = {5'd0, 5'd12};
      #1;
      chk("t6_pre_wr", 64'(wr), 64'd1);
      chk("t6_pre_hit", 64'(fwd_hit), 64'b01);
      #1;
      rst = 1'b1;
      pend.delete();
      #1;
      chk("t6_wr", 64'(wr), 64'd0);
      chk("t6_count", 64'(count), 64'd0);
      chk("t6_fwd_hit", 64'(fwd_hit), 64'd0);
      chk("t6_op_q", 64'(op_q), 64'(rf_q));
      w0 = n_wr;
      step();
      chk("t6_no_write", 64'(wr), 64'd0);
      chk("t6_count_after", 64'(count), 64'd0);
      #2;
      rst = 1'b0;
      step();

      // Random traffic with duplicates, register 0 and hold.
      for (int c = 0; c < 400; c++) begin
         drive(($urandom % 2) == 1, AW'($urandom_range(0, 7)), $urandom, ($urandom % 4) == 0);
         for (int i = 0; i < RD; i++) begin
            rr_t[i*AW +: AW] = AW'($urandom_range(0, 7));
            rf_t[i*DW +: DW] = $urandom;
         end
         rr   = rr_t;
         rf_q = rf_t;
         step();
      end
      drive(1'b0, '0, '0, 1'b0);
      repeat (6) step();
      chk("final_count", 64'(count), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
